acc_sequencer: RTL and testbench

ACC_SEQUENCER -- requirements
Module: acc_sequencer

---
 rtl/acc_sequencer.sv | 96 +++++++++
 tb/tb_acc_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/acc_sequencer.sv
// Burst sequencer for a downstream accumulator: clears it, streams a latched
// number of samples into it, then pulses a read and a completion strobe.
module acc_sequencer #(
    parameter int Word_Length = 8,
    parameter int Count_Width = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [Count_Width-1:0] length,
    input  logic                   abort,
    input  logic                   in_valid,
    input  logic [Word_Length-1:0] in_data,
    output logic                   in_ready,
    output logic                   acc_clear,
    output logic                   acc_add,
    output logic [Word_Length-1:0] acc_data,
    output logic                   acc_read,
    output logic                   busy,
    output logic                   done,
    output logic [Count_Width-1:0] sample_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_ACCUM  = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [Count_Width-1:0] len_q, len_d;
    logic [Count_Width-1:0] cnt_q, cnt_d;
    logic [Count_Width-1:0] cnt_inc;
    logic                   add_q;
    logic [Word_Length-1:0] data_q;
    logic                   xfer;

    assign in_ready = (state_q == S_ACCUM);
    assign xfer     = in_valid && in_ready;
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    len_d   = length;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR:  state_d = (len_q == '0) ? S_READ : S_ACCUM;
            S_ACCUM: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN:  state_d = S_READ;
            S_READ:   state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // A transfer in the abort cycle still counts and still owes its acc_add.
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            add_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            add_q   <= xfer;
            if (xfer) data_q <= in_data;
        end
    end

    // Read/done are suppressed in the abort cycle so a cancelled burst never completes.
    assign acc_clear    = (state_q == S_CLEAR);
    assign acc_read     = (state_q == S_READ) && !abort;
    assign done         = (state_q == S_FINISH) && !abort;
    assign busy         = (state_q != S_IDLE);
    assign acc_add      = add_q;
    assign acc_data     = data_q;
    assign sample_count = cnt_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer; transferred samples are queued and matched
// against each acc_add pulse one cycle later.
module tb_acc_sequencer;

    localparam int WL = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, start, abort, in_valid;
    logic [CW-1:0] length;
    logic [WL-1:0] in_data;
    logic          in_ready, acc_clear, acc_add, acc_read, busy, done;
    logic [WL-1:0] acc_data;
    logic [CW-1:0] sample_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [WL-1:0] sb_q[$];

    acc_sequencer #(.Word_Length(WL), .Count_Width(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .length(length), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .acc_clear(acc_clear), .acc_add(acc_add), .acc_data(acc_data),
        .acc_read(acc_read), .busy(busy), .done(done), .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record any transfer, then check the acc_add it owes.
    task automatic tick();
        logic          xfer;
        logic [WL-1:0] e;
        xfer = in_valid && in_ready;
        if (xfer) sb_q.push_back(in_data);
        @(posedge clk);
        #1;
        chk("acc_add", 32'(acc_add), 32'(xfer && !reset));
        if (acc_add === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("acc_data", 32'(acc_data), 32'(e));
        end
    endtask

    // Called right after the tick containing the last transfer.
    task automatic tail(input int exp_cnt);
        in_valid = 1'b0;
        chk("drain_in_ready", 32'(in_ready), 0);
        chk("drain_busy", 32'(busy), 1);
        chk("drain_count", 32'(sample_count), 32'(exp_cnt));
        tick();
        chk("read_acc_read", 32'(acc_read), 1);
        chk("read_done", 32'(done), 0);
        tick();
        chk("fin_done", 32'(done), 1);
        chk("fin_acc_read", 32'(acc_read), 0);
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_count", 32'(sample_count), 32'(exp_cnt));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        length = '0; in_data = '0;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_acc_clear", 32'(acc_clear), 0);
        chk("rst_acc_data", 32'(acc_data), 0);
        chk("rst_acc_read", 32'(acc_read), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(sample_count), 0);
        reset = 1'b0;
        tick();

        // Normal burst: 5, 7, 9 back to back
        start = 1'b1; length = 4'd3; tick(); start = 1'b0;
        chk("n_clear", 32'(acc_clear), 1);
        chk("n_busy", 32'(busy), 1);
        chk("n_ready_clear", 32'(in_ready), 0);
        tick();
        chk("n_clear_once", 32'(acc_clear), 0);
        chk("n_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data = 8'd5; tick();
        in_data = 8'd7; tick();
        in_data = 8'd9; tick();
        tail(3);

        // Stalled input between two samples
        start = 1'b1; length = 4'd2; tick(); start = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 8'h11; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("s_ready_stall", 32'(in_ready), 1);
            tick();
        end
        chk("s_data_hold", 32'(acc_data), 32'h11);
        in_valid = 1'b1; in_data = 8'h22; tick();
        tail(2);

        // Zero length
        start = 1'b1; length = 4'd0; tick(); start = 1'b0;
        chk("z_clear", 32'(acc_clear), 1);
        tick();
        chk("z_read", 32'(acc_read), 1);
        chk("z_ready", 32'(in_ready), 0);
        tick();
        chk("z_done", 32'(done), 1);
        tick();
        chk("z_idle", 32'(busy), 0);
        chk("z_count", 32'(sample_count), 0);

        // Maximum length
        start = 1'b1; length = 4'd15; tick(); start = 1'b0;
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_data = WL'(i * 3 + 1);
            tick();
        end
        tail(15);

        // Abort on the 2nd transfer of a length-5 burst, then restart
        start = 1'b1; length = 4'd5; tick(); start = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 8'hA1; tick();
        in_data = 8'hA2; abort = 1'b1; tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("a_busy", 32'(busy), 0);
        chk("a_read", 32'(acc_read), 0);
        tick();
        chk("a_done", 32'(done), 0);
        chk("a_read2", 32'(acc_read), 0);
        start = 1'b1; length = 4'd2; tick(); start = 1'b0;
        chk("r_clear", 32'(acc_clear), 1);
        chk("r_count", 32'(sample_count), 0);
        tick();
        in_valid = 1'b1; in_data = 8'h31; tick();
        in_data = 8'h32; tick();
        tail(2);

        // Abort beats start in IDLE
        start = 1'b1; abort = 1'b1; length = 4'd1; tick();
        start = 1'b0; abort = 1'b0;
        chk("as_busy", 32'(busy), 0);
        chk("as_clear", 32'(acc_clear), 0);

        // Reset in ACCUM
        start = 1'b1; length = 4'd4; tick(); start = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 8'h44; tick();
        in_valid = 1'b0; tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rr_busy", 32'(busy), 0);
        chk("rr_ready", 32'(in_ready), 0);
        chk("rr_data", 32'(acc_data), 0);
        chk("rr_count", 32'(sample_count), 0);
        tick(); tick();
        chk("rr_done", 32'(done), 0);
        chk("rr_read", 32'(acc_read), 0);

        // Start and length changes while busy are ignored
        start = 1'b1; length = 4'd3; tick(); start = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 8'h61; start = 1'b1; length = 4'd1; tick();
        start = 1'b0;
        chk("b_ready", 32'(in_ready), 1);
        chk("b_count", 32'(sample_count), 1);
        in_data = 8'h62; tick();
        in_data = 8'h63; tick();
        tail(3);

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
